// File: rtl/cpu_core_p_if.sv
// Data bus between cpu_core_p and the external RAM / UART I/O bridge decode.
//
// A request is held on addr/wdata/we/re until the slave answers with ready=1.
// rdata only has to be valid in the cycle where ready=1.
//
// Signals:
//   addr   master->slave  8       data bus address
//   wdata  master->slave  DATA_W  store data
//   we     master->slave  1       write request
//   re     master->slave  1       read request
//   rdata  slave->master  DATA_W  read data, sampled with ready=1
//   ready  slave->master  1       completes the current request
interface cpu_core_p_if #(
    parameter int unsigned DATA_W = 8
);
    logic [7:0]        addr;
    logic [DATA_W-1:0] wdata;
    logic              we;
    logic              re;
    logic [DATA_W-1:0] rdata;
    logic              ready;

    modport master (
        output addr,
        output wdata,
        output we,
        output re,
        input  rdata,
        input  ready
    );

    modport slave (
        input  addr,
        input  wdata,
        input  we,
        input  re,
        output rdata,
        output ready
    );
endinterface

// File: rtl/cpu_core_p.sv
// cpu_core_p: parametrised multi-cycle CPU core.
//
// Fetches 16-bit instructions from a combinational program ROM and runs them
// through a FETCH / EXEC / MEM state machine, with a terminal HALT state.
// Loads and stores go out on a registered data bus that waits for ready.
//
// Instruction word: op=[15:12] rd=[11:9] rs=[8:6] imm=[7:0].
//
// Optional feature macro: CPU_SHIFT_EN
//   defined   -> opcode D is SHL rd, opcode E is SHR rd (both update Z and C)
//   undefined -> opcodes D and E behave as NOP
//
// Parameters:
//   DATA_W  datapath / register / bus data width (8..32)
//   REG_N   number of general registers (2..8); other indices read 0,
//           and writes to them are dropped
//
// Ports:
//   clk         in   system clock, rising edge
//   rst         in   synchronous active-high reset
//   imem_addr   out  program ROM address (the PC register)
//   imem_data   in   instruction word, combinational from imem_addr
//   bus         io   data bus master (cpu_core_p_if.master)
//   zero_flag   out  Z flag register
//   carry_flag  out  C flag register
//   halted      out  core is in the HALT state
module cpu_core_p #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned REG_N  = 8
) (
    input  logic         clk,
    input  logic         rst,
    output logic [7:0]   imem_addr,
    input  logic [15:0]  imem_data,
    cpu_core_p_if.master bus,
    output logic         zero_flag,
    output logic         carry_flag,
    output logic         halted
);

    // Opcodes
    localparam logic [3:0] OpLdi  = 4'h1;
    localparam logic [3:0] OpAdd  = 4'h2;
    localparam logic [3:0] OpSub  = 4'h3;
    localparam logic [3:0] OpAnd  = 4'h4;
    localparam logic [3:0] OpOr   = 4'h5;
    localparam logic [3:0] OpXor  = 4'h6;
    localparam logic [3:0] OpLd   = 4'h7;
    localparam logic [3:0] OpSt   = 4'h8;
    localparam logic [3:0] OpJmp  = 4'h9;
    localparam logic [3:0] OpJz   = 4'hA;
    localparam logic [3:0] OpJc   = 4'hB;
    localparam logic [3:0] OpHalt = 4'hC;
`ifdef CPU_SHIFT_EN
    localparam logic [3:0] OpShl  = 4'hD;
    localparam logic [3:0] OpShr  = 4'hE;
`endif

    typedef enum logic [1:0] {
        StFetch,
        StExec,
        StMem,
        StHalt
    } state_e;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e            state_q, state_d;
    logic [7:0]        pc_q, pc_d;
    logic [15:0]       ir_q, ir_d;
    logic              z_q, z_d;
    logic              c_q, c_d;
    logic [7:0]        addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              re_q, re_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] regs_q [REG_N];

    // Register file write port, driven from the next-state logic
    logic              rf_we;
    logic [2:0]        rf_waddr;
    logic [DATA_W-1:0] rf_wdata;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic [3:0] op;
    logic [2:0] rd;
    logic [2:0] rs;
    logic [7:0] imm;

    assign op  = ir_q[15:12];
    assign rd  = ir_q[11:9];
    assign rs  = ir_q[8:6];
    assign imm = ir_q[7:0];

    // Register read: indices with no backing register read as zero.
    logic [DATA_W-1:0] rd_val;
    logic [DATA_W-1:0] rs_val;

    always_comb begin
        rd_val = '0;
        rs_val = '0;
        for (int i = 0; i < int'(REG_N); i++) begin
            if (rd == 3'(i)) rd_val = regs_q[i];
            if (rs == 3'(i)) rs_val = regs_q[i];
        end
    end

    // ------------------------------------------------------------------
    // ALU
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] alu_res;
    logic              alu_c;
    logic              alu_upd;  // opcode writes rd and updates Z/C

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_upd = 1'b0;
        case (op)
            OpAdd: begin
                // Carry is the extra top bit of the widened sum
                {alu_c, alu_res} = {1'b0, rd_val} + {1'b0, rs_val};
                alu_upd          = 1'b1;
            end
            OpSub: begin
                alu_res = rd_val - rs_val;
                alu_c   = (rd_val < rs_val);  // borrow
                alu_upd = 1'b1;
            end
            OpAnd: begin
                alu_res = rd_val & rs_val;
                alu_upd = 1'b1;
            end
            OpOr: begin
                alu_res = rd_val | rs_val;
                alu_upd = 1'b1;
            end
            OpXor: begin
                alu_res = rd_val ^ rs_val;
                alu_upd = 1'b1;
            end
`ifdef CPU_SHIFT_EN
            OpShl: begin
                alu_res = {rd_val[DATA_W-2:0], 1'b0};
                alu_c   = rd_val[DATA_W-1];
                alu_upd = 1'b1;
            end
            OpShr: begin
                alu_res = {1'b0, rd_val[DATA_W-1:1]};
                alu_c   = rd_val[0];
                alu_upd = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        z_d      = z_q;
        c_d      = c_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        re_d     = re_q;
        we_d     = we_q;
        rf_we    = 1'b0;
        rf_waddr = rd;
        rf_wdata = alu_res;

        unique case (state_q)
            StFetch: begin
                ir_d    = imem_data;
                state_d = StExec;
            end

            StExec: begin
                // Every instruction advances the PC here; taken jumps override
                pc_d    = pc_q + 8'd1;
                state_d = StFetch;
                case (op)
                    OpLdi: begin
                        rf_we    = 1'b1;
                        rf_wdata = DATA_W'(imm);
                    end
                    OpLd: begin
                        re_d    = 1'b1;
                        addr_d  = imm;
                        state_d = StMem;
                    end
                    OpSt: begin
                        we_d    = 1'b1;
                        addr_d  = imm;
                        wdata_d = rd_val;
                        state_d = StMem;
                    end
                    OpJmp: pc_d = imm;
                    OpJz: begin
                        if (z_q) pc_d = imm;
                    end
                    OpJc: begin
                        if (c_q) pc_d = imm;
                    end
                    OpHalt: state_d = StHalt;
                    default: begin
                        // ALU ops; NOP and disabled opcodes fall through untouched
                        if (alu_upd) begin
                            rf_we = 1'b1;
                            z_d   = (alu_res == '0);
                            c_d   = alu_c;
                        end
                    end
                endcase
            end

            StMem: begin
                // addr/wdata stay put; only the request strobes drop on completion
                if (bus.ready) begin
                    if (re_q) begin
                        rf_we    = 1'b1;
                        rf_wdata = bus.rdata;
                    end
                    re_d    = 1'b0;
                    we_d    = 1'b0;
                    state_d = StFetch;
                end
            end

            StHalt: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StFetch;
            pc_q    <= '0;
            ir_q    <= '0;
            z_q     <= 1'b0;
            c_q     <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            re_q    <= 1'b0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            z_q     <= z_d;
            c_q     <= c_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            re_q    <= re_d;
            we_q    <= we_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(REG_N); i++) begin
                regs_q[i] <= '0;
            end
        end else if (rf_we) begin
            for (int i = 0; i < int'(REG_N); i++) begin
                if (rf_waddr == 3'(i)) regs_q[i] <= rf_wdata;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign imem_addr  = pc_q;
    assign bus.addr   = addr_q;
    assign bus.wdata  = wdata_q;
    assign bus.re     = re_q;
    assign bus.we     = we_q;
    assign zero_flag  = z_q;
    assign carry_flag = c_q;
    assign halted     = (state_q == StHalt);

endmodule

// File: tb/tb_cpu_core_p.sv
`timescale 1ns/1ps
module tb_cpu_core_p;

    localparam int unsigned DW = 8;
    localparam int unsigned RN = 8;
    localparam longint unsigned MASK = (64'd1 << DW) - 64'd1;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  imem_addr;
    logic [15:0] imem_data;
    logic        zero_flag;
    logic        carry_flag;
    logic        halted;

    cpu_core_p_if #(.DATA_W(DW)) bus ();

    cpu_core_p #(.DATA_W(DW), .REG_N(RN)) dut (
        .clk       (clk),
        .rst       (rst),
        .imem_addr (imem_addr),
        .imem_data (imem_data),
        .bus       (bus),
        .zero_flag (zero_flag),
        .carry_flag(carry_flag),
        .halted    (halted)
    );

    always #5 clk = ~clk;

    logic [15:0] rom [256];
    assign imem_data = rom[imem_addr];

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Bus slave: RAM with a queue of per-request wait counts
    // ------------------------------------------------------------------
    logic [DW-1:0] ram [256];
    int  wq[$];
    bit  active;
    int  left;
    int  we22_cycles;
    int  re_cycles;

    initial begin
        bus.ready = 1'b0;
        bus.rdata = '0;
        active    = 1'b0;
        left      = 0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.we === 1'b1 && bus.addr === 8'h22) we22_cycles++;
            if (bus.re === 1'b1) re_cycles++;
            if (bus.re === 1'b1 || bus.we === 1'b1) begin
                if (!active) begin
                    active = 1'b1;
                    left   = (wq.size() > 0) ? wq.pop_front() : 0;
                end
                if (left == 0) begin
                    bus.ready = 1'b1;
                    bus.rdata = ram[bus.addr];
                    if (bus.we === 1'b1) ram[bus.addr] = bus.wdata;
                    active = 1'b0;
                end else begin
                    bus.ready = 1'b0;
                    bus.rdata = DW'($urandom);
                    left--;
                end
            end else begin
                // Junk ready/rdata outside a request must be ignored
                bus.ready = 1'($urandom_range(0, 1));
                bus.rdata = DW'($urandom);
                active    = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Instruction-level reference model with cycle phases
    // ph: 0 fetch cycle, 1 execute cycle, 2 memory wait cycle, 3 halted
    // ------------------------------------------------------------------
    bit            m_on = 1'b0;
    int            ph;
    logic [7:0]    m_pc;
    logic [15:0]   m_ir;
    logic [DW-1:0] m_r [8];
    bit            m_z, m_c;
    logic [DW-1:0] m_mem [256];
    bit            m_ld;
    logic [7:0]    m_addr;
    logic [DW-1:0] m_wd;
    logic [7:0]    prev_addr;
    bit            saw_wrap;

    function automatic longint unsigned rget(input int i);
        return (i < int'(RN)) ? longint'(m_r[i]) : 64'd0;
    endfunction

    task automatic rset(input int i, input longint unsigned v);
        if (i < int'(RN)) m_r[i] = DW'(v & MASK);
    endtask

    task automatic model_reset();
        m_on = 1'b1;
        ph   = 0;
        m_pc = 8'h00;
        m_ir = 16'h0000;
        m_z  = 1'b0;
        m_c  = 1'b0;
        m_ld = 1'b0;
        for (int i = 0; i < 8; i++) m_r[i] = '0;
    endtask

    task automatic model_exec();
        int               op, rd, rs;
        logic [7:0]       imm, nxt;
        longint unsigned  a, b, r;
        op  = int'(m_ir[15:12]);
        rd  = int'(m_ir[11:9]);
        rs  = int'(m_ir[8:6]);
        imm = m_ir[7:0];
        a   = rget(rd);
        b   = rget(rs);
        nxt = m_pc + 8'd1;
        ph  = 0;
        case (op)
            1: rset(rd, longint'(imm));
            2: begin r = a + b; m_c = (r > MASK); r = r & MASK; m_z = (r == 0); rset(rd, r); end
            3: begin m_c = (a < b); r = (a - b) & MASK; m_z = (r == 0); rset(rd, r); end
            4: begin r = a & b; m_c = 1'b0; m_z = (r == 0); rset(rd, r); end
            5: begin r = a | b; m_c = 1'b0; m_z = (r == 0); rset(rd, r); end
            6: begin r = a ^ b; m_c = 1'b0; m_z = (r == 0); rset(rd, r); end
            7: begin m_ld = 1'b1; m_addr = imm; ph = 2; end
            8: begin m_ld = 1'b0; m_addr = imm; m_wd = DW'(a); ph = 2; end
            9: nxt = imm;
            10: if (m_z) nxt = imm;
            11: if (m_c) nxt = imm;
            12: ph = 3;
`ifdef CPU_SHIFT_EN
            13: begin m_c = ((a >> (DW - 1)) & 1) != 0; r = (a << 1) & MASK;
                      m_z = (r == 0); rset(rd, r); end
            14: begin m_c = (a & 1) != 0; r = a >> 1; m_z = (r == 0); rset(rd, r); end
`endif
            default: ;
        endcase
        m_pc = nxt;
    endtask

    task automatic model_step();
        case (ph)
            0: begin m_ir = rom[m_pc]; ph = 1; end
            1: model_exec();
            2: begin
                if (bus.ready === 1'b1) begin
                    if (m_ld) rset(int'(m_ir[11:9]), longint'(m_mem[m_addr]));
                    else m_mem[m_addr] = m_wd;
                    ph = 0;
                end
            end
            default: ;
        endcase
    endtask

    // Compare process: outputs sampled mid-cycle, then model advances
    always @(negedge clk) begin
        if (m_on) begin
            chk("imem_addr",  imem_addr,  m_pc);
            chk("bus_re",     bus.re,     (ph == 2) && m_ld);
            chk("bus_we",     bus.we,     (ph == 2) && !m_ld);
            chk("halted",     halted,     ph == 3);
            chk("zero_flag",  zero_flag,  m_z);
            chk("carry_flag", carry_flag, m_c);
            if (ph == 2) begin
                chk("bus_addr", bus.addr, m_addr);
                if (!m_ld) chk("bus_wdata", bus.wdata, m_wd);
            end
            if (prev_addr === 8'hFF && imem_addr === 8'h00) saw_wrap = 1'b1;
        end
        prev_addr = imem_addr;
        if (rst) model_reset();
        else if (m_on) model_step();
    end

    // ------------------------------------------------------------------
    // Scenario helpers
    // ------------------------------------------------------------------
    task automatic clear_all();
        for (int i = 0; i < 256; i++) begin
            rom[i]   = 16'hC000;
            ram[i]   = '0;
            m_mem[i] = '0;
        end
        wq.delete();
        we22_cycles = 0;
        re_cycles   = 0;
        saw_wrap    = 1'b0;
    endtask

    task automatic poke(input int a, input logic [DW-1:0] v);
        ram[a]   = v;
        m_mem[a] = v;
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic wait_halt(input string name);
        bit done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            #1;
            if (halted === 1'b1) done = 1'b1;
        end
        chk(name, done, 1'b1);
        repeat (20) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // S1: ADD wrap with flags, store result
        clear_all();
        poke(8'h40, 8'h55);
        rom[0] = 16'h1205;  // LDI r1,0x05
        rom[1] = 16'h14FB;  // LDI r2,0xFB
        rom[2] = 16'h2280;  // ADD r1,r2
        rom[3] = 16'h8240;  // ST r1,[0x40]
        rom[4] = 16'hC000;  // HALT
        pulse_reset();
        @(negedge clk);
        #1;
        chk("rst_imem_addr", imem_addr, 8'h00);
        chk("rst_halted", halted, 1'b0);
        chk("rst_bus_re", bus.re, 1'b0);
        chk("rst_bus_addr", bus.addr, 8'h00);
        wait_halt("s1_halt");
        chk("s1_ram40", ram[8'h40], 8'h00);
        chk("s1_zero", zero_flag, 1'b1);
        chk("s1_carry", carry_flag, 1'b1);
        chk("s1_pc_frozen", imem_addr, 8'h05);
        chk("s1_model_r1", m_r[1], 8'h00);

        // S2: SUB borrow, untaken JZ, taken JC
        clear_all();
        rom[8'h00] = 16'h1203;  // LDI r1,0x03
        rom[8'h01] = 16'h1405;  // LDI r2,0x05
        rom[8'h02] = 16'h3280;  // SUB r1,r2
        rom[8'h03] = 16'hA020;  // JZ 0x20 (not taken)
        rom[8'h04] = 16'hB010;  // JC 0x10 (taken)
        rom[8'h10] = 16'h8241;  // ST r1,[0x41]
        rom[8'h11] = 16'hC000;  // HALT
        rom[8'h20] = 16'h8220;  // trap if JZ were taken
        pulse_reset();
        wait_halt("s2_halt");
        chk("s2_ram41", ram[8'h41], 8'hFE);
        chk("s2_ram20", ram[8'h20], 8'h00);
        chk("s2_carry", carry_flag, 1'b1);
        chk("s2_zero", zero_flag, 1'b0);
        chk("s2_pc_frozen", imem_addr, 8'h12);
        chk("s2_model_r1", m_r[1], 8'hFE);

        // S3: wait states, load, logic ops, opcode D
        clear_all();
        poke(8'h24, 8'h99);
        wq.push_back(3);
        rom[0]  = 16'h12A5;  // LDI r1,0xA5
        rom[1]  = 16'h8222;  // ST r1,[0x22]   (3 wait cycles)
        rom[2]  = 16'h7622;  // LD r3,[0x22]   (ready at once)
        rom[3]  = 16'h8623;  // ST r3,[0x23]
        rom[4]  = 16'h180F;  // LDI r4,0x0F
        rom[5]  = 16'h4840;  // AND r4,r1 -> 0x05
        rom[6]  = 16'h5840;  // OR  r4,r1 -> 0xA5
        rom[7]  = 16'h6840;  // XOR r4,r1 -> 0x00
        rom[8]  = 16'h8824;  // ST r4,[0x24]
        rom[9]  = 16'h1A81;  // LDI r5,0x81
        rom[10] = 16'hDA00;  // SHL r5 (or NOP)
        rom[11] = 16'h8A25;  // ST r5,[0x25]
        rom[12] = 16'hC000;  // HALT
        pulse_reset();
        wait_halt("s3_halt");
        chk("s3_we22_cycles", we22_cycles, 4);
        chk("s3_re_cycles", re_cycles, 1);
        chk("s3_ram23", ram[8'h23], 8'hA5);
        chk("s3_ram24", ram[8'h24], 8'h00);
        chk("s3_pc_frozen", imem_addr, 8'h0D);
`ifdef CPU_SHIFT_EN
        chk("s3_ram25", ram[8'h25], 8'h02);
        chk("s3_carry", carry_flag, 1'b1);
        chk("s3_zero", zero_flag, 1'b0);
`else
        chk("s3_ram25", ram[8'h25], 8'h81);
        chk("s3_carry", carry_flag, 1'b0);
        chk("s3_zero", zero_flag, 1'b1);
`endif

        // S4: PC wraps from 0xFF to 0x00
        clear_all();
        rom[8'h00] = 16'hA003;  // JZ 0x03
        rom[8'h01] = 16'h90FF;  // JMP 0xFF
        rom[8'hFF] = 16'h3000;  // SUB r0,r0 -> Z=1
        pulse_reset();
        wait_halt("s4_halt");
        chk("s4_wrap_seen", saw_wrap, 1'b1);
        chk("s4_pc_frozen", imem_addr, 8'h04);
        chk("s4_zero", zero_flag, 1'b1);
        chk("s4_carry", carry_flag, 1'b0);

        // S5: reset in the middle of a stalled load
        clear_all();
        poke(8'h30, 8'h3C);
        wq.push_back(10);
        rom[0] = 16'h12FF;  // LDI r1,0xFF
        rom[1] = 16'h1401;  // LDI r2,0x01
        rom[2] = 16'h2280;  // ADD r1,r2 -> Z=1 C=1
        rom[3] = 16'h7430;  // LD r2,[0x30]
        rom[4] = 16'h8431;  // ST r2,[0x31]
        rom[5] = 16'hC000;  // HALT
        pulse_reset();
        begin
            bit seen = 1'b0;
            for (int i = 0; i < 50 && !seen; i++) begin
                @(negedge clk);
                if (bus.re === 1'b1) seen = 1'b1;
            end
            chk("s5_load_started", seen, 1'b1);
        end
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("s5_rst_bus_re", bus.re, 1'b0);
        chk("s5_rst_imem_addr", imem_addr, 8'h00);
        chk("s5_rst_halted", halted, 1'b0);
        chk("s5_rst_zero", zero_flag, 1'b0);
        chk("s5_rst_carry", carry_flag, 1'b0);
        wait_halt("s5_halt");
        chk("s5_ram31", ram[8'h31], 8'h3C);
        chk("s5_pc_frozen", imem_addr, 8'h06);
        chk("s5_zero", zero_flag, 1'b1);
        chk("s5_carry", carry_flag, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
